// File: rtl/fir_pkg.sv
// Shared definitions for the serial 4-tap FIR: Q-format widths, FSM encoding, default taps.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fir_pkg;

    // Q-format widths (total bits / fractional bits)
    localparam int NB_INPUT   = 16;
    localparam int NBF_INPUT  = 15;
    localparam int NB_COEF    = 16;
    localparam int NBF_COEF   = 15;
    localparam int NB_OUTPUT  = 18;
    localparam int NBF_OUTPUT = 15;
    localparam int NB_PROD    = NB_INPUT + NB_COEF;      // 32
    localparam int NBF_PROD   = NBF_INPUT + NBF_COEF;    // 30

    localparam int N_TAPS = 4;
    localparam int NB_TAP = $clog2(N_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // 10 kHz low-pass set, symmetric: outer taps small, inner taps large
    localparam logic signed [NB_COEF-1:0] COEF_OUTER = 16'sh04F0;
    localparam logic signed [NB_COEF-1:0] COEF_INNER = 16'sh3B0F;

    function automatic logic signed [NB_COEF-1:0] default_coef(input int idx);
        if (idx == 0 || idx == N_TAPS - 1) begin
            return COEF_OUTER;
        end
        return COEF_INNER;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file with reset-to-defaults, qualified write port and async tap read.
// Latency: write lands and ack pulses one cycle after the strobe; read is combinational.
// Backpressure: none; caller only asserts we when a write may be taken.
// Ports: clk/rst_n (sync active-low); we/addr/wdata write; ack write-taken pulse; tap/coef read.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [NB_TAP-1:0]         addr,
    input  logic signed [NB_COEF-1:0] wdata,
    input  logic [NB_TAP-1:0]         tap,
    output logic signed [NB_COEF-1:0] coef,
    output logic                      ack
);
    logic signed [NB_COEF-1:0] bank [N_TAPS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                bank[k] <= default_coef(k);
            end
            ack <= 1'b0;
        end else begin
            ack <= we;
            if (we) begin
                bank[addr] <= wdata;
            end
        end
    end

    assign coef = bank[tap];

endmodule

// File: rtl/sat_trunc_fp.sv
// Fixed-point narrowing: floor-truncate fractional LSBs, then saturate to the output range.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data - wide signed value Q(NB_XI,NBF_XI); o_data - narrowed signed value Q(NB_XO,NBF_XO).
module SatTruncFP #(
    parameter int NB_XI  = 32,
    parameter int NBF_XI = 30,
    parameter int NB_XO  = 16,
    parameter int NBF_XO = 15
) (
    input  logic signed [NB_XI-1:0] i_data,
    output logic signed [NB_XO-1:0] o_data
);
    localparam int DROP = NBF_XI - NBF_XO;
    localparam int NB_T = NB_XI - DROP;

    logic signed [NB_T-1:0] trunc;
    logic [NB_T-NB_XO:0]    upper;
    logic                   fits;
    logic                   unused_lsb;

    // Dropping LSBs of a two's complement value is a floor operation
    assign trunc      = i_data[NB_XI-1:DROP];
    assign unused_lsb = ^i_data[DROP-1:0];

    // Value fits when every bit above the output sign bit copies the sign
    assign upper = trunc[NB_T-1:NB_XO-1];
    assign fits  = (&upper) | (~|upper);

    always_comb begin
        o_data = trunc[NB_XO-1:0];
        if (!fits) begin
            o_data = trunc[NB_T-1] ? {1'b1, {(NB_XO-1){1'b0}}}
                                   : {1'b0, {(NB_XO-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed 4-tap FIR sequencer: one shared multiplier walks the taps, one per cycle.
// Latency: result valid N_TAPS+1 cycles after the accept edge; one sample per N_TAPS+2 cycles.
// Backpressure: o_ready low outside IDLE; result held in OUT until i_ready, input held by source.
// Ports: i_clk/i_rst (sync active-low); i_valid/o_ready/i_data sample in; o_valid/i_ready/o_data
//        result out; i_coef_we/i_coef_addr/i_coef_data/o_coef_ack coef write; o_busy not IDLE.
module fir_serial_ctrl
    import fir_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_INPUT-1:0]  i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_OUTPUT-1:0] o_data,
    input  logic                 i_coef_we,
    input  logic [NB_TAP-1:0]    i_coef_addr,
    input  logic [NB_COEF-1:0]   i_coef_data,
    output logic                 o_coef_ack,
    output logic                 o_busy
);
    state_t state, state_nxt;

    logic signed [NB_INPUT-1:0]  x [N_TAPS];
    logic signed [NB_OUTPUT-1:0] acc;
    logic [NB_TAP-1:0]           tap;
    logic                        accept;
    logic                        coef_we_ok;
    logic                        last_tap;

    logic signed [NB_COEF-1:0]   coef_tap;
    logic signed [NB_INPUT-1:0]  x_tap;
    logic signed [NB_PROD-1:0]   prod;
    logic signed [NB_COEF-1:0]   prod_st;

    assign last_tap = (tap == NB_TAP'(N_TAPS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Not ready while reset is held, so nothing is taken during reset
                o_ready = i_rst;
                if (i_valid && i_rst) begin
                    accept    = 1'b1;
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (last_tap) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Coefficients change only between computations; a same-cycle sample accept wins
    assign coef_we_ok = i_coef_we && (state == ST_IDLE) && !accept;

    // ---------------- Coefficient bank ----------------
    fir_coef_bank u_coef_bank (
        .clk   (i_clk),
        .rst_n (i_rst),
        .we    (coef_we_ok),
        .addr  (i_coef_addr),
        .wdata (i_coef_data),
        .tap   (tap),
        .coef  (coef_tap),
        .ack   (o_coef_ack)
    );

    // ---------------- Shared multiplier ----------------
    // x[0] is the newest sample and pairs with coef[0]
    assign x_tap = x[tap];
    assign prod  = NB_PROD'(x_tap) * NB_PROD'(coef_tap);

    SatTruncFP #(
        .NB_XI  (NB_PROD),
        .NBF_XI (NBF_PROD),
        .NB_XO  (NB_COEF),
        .NBF_XO (NBF_COEF)
    ) u_sat_trunc (
        .i_data (prod),
        .o_data (prod_st)
    );

    // ---------------- Datapath ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x[k] <= '0;
            end
            acc <= '0;
            tap <= '0;
        end else if (accept) begin
            for (int k = N_TAPS - 1; k > 0; k--) begin
                x[k] <= x[k-1];
            end
            x[0] <= i_data;
            acc  <= '0;
            tap  <= '0;
        end else if (state == ST_MAC) begin
            // Four Q(16,15) terms always fit Q(18,15): plain sign-extended add
            acc <= acc + NB_OUTPUT'(prod_st);
            tap <= tap + NB_TAP'(1);
        end
    end

    // acc is frozen outside MAC, so the result is stable for the whole OUT phase
    assign o_data = acc;
    assign o_busy = (state != ST_IDLE);

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
- Sequencer for a time-multiplexed 4-tap low-pass FIR built on one shared multiplier.
- Accepts one sample per handshake and walks the multiplier across all taps, one tap per cycle.
- Accumulates the saturated, truncated products and presents the result with a valid/ready handshake.
- Owns a runtime-writable coefficient bank that resets to the 10 kHz low-pass set. Sits between the sample source and the downstream consumer.

Parameters:
- NB_INPUT, 16, sample width, signed Q(16,15)
- NB_COEF, 16, coefficient width, signed Q(16,15)
- NB_OUTPUT, 18, result width, signed Q(18,15)
- N_TAPS, 4, number of taps; tap index width NB_TAP = clog2(N_TAPS)

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-low reset
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample
- i_data  in  NB_INPUT  input sample
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_data  out  NB_OUTPUT  filtered result
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  NB_TAP  coefficient index
- i_coef_data  in  NB_COEF  coefficient value
- o_coef_ack  out  1  one-cycle pulse: write accepted
- o_busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-low.
- Reset (i_rst=0 at a rising edge), effective the next cycle:
  - state=IDLE; delay line x[0..N_TAPS-1]=0; accumulator=0; tap=0.
  - o_data=0, o_valid=0, o_coef_ack=0, o_busy=0.
  - o_ready=0 while reset is held, 1 afterwards.
  - Coefficients return to the defaults 0x04F0, 0x3B0F, 0x3B0F, 0x04F0.
  - Reset mid-MAC or mid-OUT aborts the computation; no o_valid is produced.
- FSM, three states:
  - IDLE: o_ready=1. On i_valid&o_ready:
    - shift x[k]<=x[k-1], x[0]<=i_data;
    - acc<=0, tap<=0; go to MAC.
  - MAC: o_ready=0.
    - Each cycle: acc <= acc + st(x[tap]*coef[tap]); tap <= tap+1.
    - When tap==N_TAPS-1, go to OUT after that cycle's accumulation.
  - OUT: o_valid=1 and o_data=acc, both held stable until i_valid-independent i_ready=1.
    - On o_valid&i_ready, go to IDLE; o_valid drops the next cycle.
- Latency and throughput:
  - Accept edge is cycle 0; o_valid rises at cycle N_TAPS+1 (cycle 5 at default).
  - With i_ready held high, throughput is one sample per N_TAPS+2 cycles.
- Arithmetic:
  - Product: full precision Q(32,30).
  - st(): drop the 15 LSBs (floor), then saturate to Q(16,15), range [0x8000, 0x7FFF].
  - Accumulate sign-extended to 18 bits. The sum of 4 Q(16,15) values always fits Q(18,15), so no wrap or saturation is needed on the accumulator.
- Tap mapping: coef[0] multiplies the newest sample (x[0]); coef[N_TAPS-1] multiplies the oldest.
- Coefficient writes:
  - Accepted only in IDLE, and only when no sample is accepted in the same cycle (a sample accept has priority).
  - Accepted write: bank[i_coef_addr]<=i_coef_data, and o_coef_ack=1 the next cycle.
  - Writes in MAC or OUT, or colliding with an accept, are dropped with no ack.
  - Coefficients are therefore never modified during a computation.
- Backpressure: while in OUT with i_ready=0, i_valid is ignored and no input sample is lost (the source holds it, since o_ready=0).

Decomposition:
- Shared package fir_pkg holds:
  - Q-format widths: NB_INPUT, NB_COEF, NB_OUTPUT, product width 32, product fractional bits 30;
  - FSM state encoding (IDLE, MAC, OUT);
  - default coefficient constants.
- Saturation/truncation reuses the team's existing SatTruncFP (32,30)->(16,15) instance, one only.
- One natural sub-module: fir_coef_bank. It holds the register file, default reset values and write/ack logic, and has an asynchronous read port indexed by tap.

Test Plan:
- Default coefs, impulse 0x7FFF then three zeros, i_ready=1 -> o_data sequence 0x004EF, 0x03B0E, 0x03B0E, 0x004EF, then 0x00000. Each o_valid rises 5 cycles after its accept; one result per 6 cycles.
- Default coefs, constant input 0x4000 for 8 samples -> from the 4th result on, o_data=0x03FFE (632+7559+7559+632).
- Write all coefs 0x8000 (4 acks) then four samples of 0x8000 -> every product saturates to 0x7FFF; 4th result is 0x1FFFC.
- Backpressure: hold i_ready=0 for 10 cycles in OUT -> o_valid=1 and o_data stable throughout; o_ready=0; i_valid pulses ignored; result delivered on the cycle i_ready rises.
- Coef write during MAC -> no ack, bank unchanged. Write 0x0000 to addr 0 in IDLE -> ack next cycle; next impulse 0x7FFF drops the 0x004EF term (first result 0x00000).
- Assert i_rst=0 during the 2nd MAC cycle -> next cycle: IDLE, o_valid=0, o_data=0, coefs default. After release, o_ready=1 and an impulse reproduces scenario 1.
